// File: rtl/axilite_pkg.sv
// Shared definitions for the AXI-Lite arbiter: response codes and arbiter state encoding.
package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA
  } arb_state_t;

endpackage

// File: rtl/axilite_rr_pick.sv
// Round-robin picker: first requester at or after rr_ptr, wrapping modulo NUM_M.
// Ports: req (request vector), rr_ptr (search start), win_oh_c/win_idx_c (winner), win_vld_c (any request).
module axilite_rr_pick #(
  parameter int unsigned NUM_M = 2,
  parameter int unsigned IDXW  = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDXW-1:0]  rr_ptr,
  output logic [NUM_M-1:0] win_oh_c,
  output logic [IDXW-1:0]  win_idx_c,
  output logic             win_vld_c
);

  logic [IDXW-1:0] idx;

  // Scan from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    win_oh_c  = '0;
    win_idx_c = '0;
    win_vld_c = |req;
    idx       = '0;
    for (int k = int'(NUM_M) - 1; k >= 0; k--) begin
      idx = IDXW'((32'(rr_ptr) + 32'(k)) % NUM_M);
      if (req[idx]) begin
        win_oh_c      = '0;
        win_oh_c[idx] = 1'b1;
        win_idx_c     = idx;
      end
    end
  end

endmodule

// File: rtl/axilite_arb2.sv
// Round-robin arbiter sharing one single-outstanding AXI-Lite slave between NUM_M masters.
// One whole transaction (AW+W+B or AR+R) is granted at a time; the granted master's channels are
// forwarded, all others see valid/ready low. Responses/read data are broadcast to every slice.
// Ports: aclk/areset (sync, active high), s_axi_* per-master slices, m_axi_* shared slave side,
// grant_id (granted master), busy (transaction in flight).
module axilite_arb2
  import axilite_pkg::*;
#(
  parameter int unsigned NUM_M = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_M-1:0]          s_axi_awvalid,
  output logic [NUM_M-1:0]          s_axi_awready,
  input  logic [NUM_M*AW-1:0]       s_axi_awaddr,
  input  logic [NUM_M-1:0]          s_axi_wvalid,
  output logic [NUM_M-1:0]          s_axi_wready,
  input  logic [NUM_M*DW-1:0]       s_axi_wdata,
  output logic [NUM_M-1:0]          s_axi_bvalid,
  input  logic [NUM_M-1:0]          s_axi_bready,
  output logic [NUM_M*2-1:0]        s_axi_bresp,
  input  logic [NUM_M-1:0]          s_axi_arvalid,
  output logic [NUM_M-1:0]          s_axi_arready,
  input  logic [NUM_M*AW-1:0]       s_axi_araddr,
  output logic [NUM_M-1:0]          s_axi_rvalid,
  input  logic [NUM_M-1:0]          s_axi_rready,
  output logic [NUM_M*DW-1:0]       s_axi_rdata,
  output logic [NUM_M*2-1:0]        s_axi_rresp,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [AW-1:0]             m_axi_awaddr,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic [DW-1:0]             m_axi_wdata,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  input  logic [1:0]                m_axi_bresp,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [AW-1:0]             m_axi_araddr,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic [DW-1:0]             m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  output logic [$clog2(NUM_M)-1:0]  grant_id,
  output logic                      busy
);

  localparam int unsigned IDXW = $clog2(NUM_M);

  arb_state_t      state_q, state_d;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;

  logic [NUM_M-1:0] req, win_oh;
  logic [IDXW-1:0]  win_idx, nxt_ptr;
  logic             win_vld;

  logic            sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic [AW-1:0]   sel_awaddr, sel_araddr;
  logic [DW-1:0]   sel_wdata;
  logic            aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
  logic [NUM_M-1:0] grant_oh;

  assign req = s_axi_awvalid | s_axi_arvalid;

  axilite_rr_pick #(.NUM_M(NUM_M), .IDXW(IDXW)) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .win_oh_c  (win_oh),
    .win_idx_c (win_idx),
    .win_vld_c (win_vld)
  );

  // Select the granted master's request-side signals.
  always_comb begin
    sel_awvalid = 1'b0;
    sel_awaddr  = '0;
    sel_wvalid  = 1'b0;
    sel_wdata   = '0;
    sel_bready  = 1'b0;
    sel_arvalid = 1'b0;
    sel_araddr  = '0;
    sel_rready  = 1'b0;
    for (int i = 0; i < int'(NUM_M); i++) begin
      if (grant_q == IDXW'(i)) begin
        sel_awvalid = s_axi_awvalid[i];
        sel_awaddr  = s_axi_awaddr[i*AW +: AW];
        sel_wvalid  = s_axi_wvalid[i];
        sel_wdata   = s_axi_wdata[i*DW +: DW];
        sel_bready  = s_axi_bready[i];
        sel_arvalid = s_axi_arvalid[i];
        sel_araddr  = s_axi_araddr[i*AW +: AW];
        sel_rready  = s_axi_rready[i];
      end
    end
  end

  assign nxt_ptr = (grant_q == IDXW'(NUM_M - 1)) ? '0 : grant_q + IDXW'(1);

  // Next-state and state-gated handshake forwarding.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awaddr  = sel_awaddr;
    m_axi_wdata   = sel_wdata;
    m_axi_araddr  = sel_araddr;
    aw_rdy        = 1'b0;
    w_rdy         = 1'b0;
    b_vld         = 1'b0;
    ar_rdy        = 1'b0;
    r_vld         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          grant_d = win_idx;
          // Within one master a pending write takes precedence over a read.
          state_d = (|(win_oh & s_axi_awvalid)) ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_WR: begin
        m_axi_awvalid = sel_awvalid & ~aw_done_q;
        m_axi_wvalid  = sel_wvalid & ~w_done_q;
        aw_rdy        = m_axi_awready & ~aw_done_q;
        w_rdy         = m_axi_wready & ~w_done_q;
        aw_done_d     = aw_done_q | (m_axi_awvalid & m_axi_awready);
        w_done_d      = w_done_q | (m_axi_wvalid & m_axi_wready);
        if (aw_done_d && w_done_d) begin
          state_d   = ST_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_WR_RESP: begin
        b_vld        = m_axi_bvalid;
        m_axi_bready = sel_bready;
        if (m_axi_bvalid && sel_bready) begin
          state_d  = ST_IDLE;
          rr_ptr_d = nxt_ptr;
        end
      end
      ST_RD_ADDR: begin
        m_axi_arvalid = sel_arvalid;
        ar_rdy        = m_axi_arready;
        if (sel_arvalid && m_axi_arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        r_vld        = m_axi_rvalid;
        m_axi_rready = sel_rready;
        if (m_axi_rvalid && sel_rready) begin
          state_d  = ST_IDLE;
          rr_ptr_d = nxt_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Fan granted-master handshakes out to its slice only; responses go to every slice.
  assign grant_oh      = NUM_M'(1) << grant_q;
  assign s_axi_awready = {NUM_M{aw_rdy}} & grant_oh;
  assign s_axi_wready  = {NUM_M{w_rdy}} & grant_oh;
  assign s_axi_bvalid  = {NUM_M{b_vld}} & grant_oh;
  assign s_axi_arready = {NUM_M{ar_rdy}} & grant_oh;
  assign s_axi_rvalid  = {NUM_M{r_vld}} & grant_oh;
  assign s_axi_bresp   = {NUM_M{m_axi_bresp}};
  assign s_axi_rdata   = {NUM_M{m_axi_rdata}};
  assign s_axi_rresp   = {NUM_M{m_axi_rresp}};

  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axilite_arb2.sv
// Bench for axilite_arb2: two bounded master drivers, a 128-word single-outstanding slave model,
// a table of directed transactions, corner-case sequences and a randomized phase checked
// against a word-array reference memory.
module tb_axilite_arb2;
  import axilite_pkg::*;

  localparam int NM  = 2;
  localparam int TMO = 200;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [NM-1:0]    s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [NM-1:0]    s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic [NM-1:0]    s_axi_rvalid, s_axi_rready;
  logic [NM*32-1:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [NM*2-1:0]  s_axi_bresp, s_axi_rresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic [0:0]  grant_id;
  logic        busy;

  axilite_arb2 #(.NUM_M(NM), .AW(32), .DW(32)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp),
    .grant_id(grant_id), .busy(busy)
  );

  // Per-master driver registers, packed onto the DUT vectors.
  logic        awvalid_r [NM];
  logic        wvalid_r  [NM];
  logic        bready_r  [NM];
  logic        arvalid_r [NM];
  logic        rready_r  [NM];
  logic [31:0] awaddr_r  [NM];
  logic [31:0] wdata_r   [NM];
  logic [31:0] araddr_r  [NM];

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      s_axi_awvalid[i]          = awvalid_r[i];
      s_axi_wvalid[i]           = wvalid_r[i];
      s_axi_bready[i]           = bready_r[i];
      s_axi_arvalid[i]          = arvalid_r[i];
      s_axi_rready[i]           = rready_r[i];
      s_axi_awaddr[i*32 +: 32]  = awaddr_r[i];
      s_axi_wdata[i*32 +: 32]   = wdata_r[i];
      s_axi_araddr[i*32 +: 32]  = araddr_r[i];
    end
  end

  // Slave model: word addressed, 128 words, DECERR beyond, optional random ready stalls.
  logic        slv_rand;
  logic        sl_rnd, aw_have, w_have, sl_bvalid, sl_rvalid;
  logic [31:0] aw_addr_l, w_data_l, sl_rdata;
  logic [1:0]  sl_bresp, sl_rresp;
  logic [31:0] sl_mem [128];

  assign m_axi_awready = !aw_have && !sl_bvalid && (sl_rnd || !slv_rand);
  assign m_axi_wready  = !w_have && !sl_bvalid && (sl_rnd || !slv_rand);
  assign m_axi_arready = !sl_rvalid && (sl_rnd || !slv_rand);
  assign m_axi_bvalid  = sl_bvalid;
  assign m_axi_bresp   = sl_bresp;
  assign m_axi_rvalid  = sl_rvalid;
  assign m_axi_rdata   = sl_rdata;
  assign m_axi_rresp   = sl_rresp;

  always @(posedge aclk) begin
    sl_rnd <= 1'($urandom);
    if (areset) begin
      aw_have <= 1'b0; w_have <= 1'b0; sl_bvalid <= 1'b0; sl_rvalid <= 1'b0;
      sl_rdata <= '0; sl_rresp <= '0; sl_bresp <= '0; aw_addr_l <= '0; w_data_l <= '0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin aw_have <= 1'b1; aw_addr_l <= m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready) begin w_have <= 1'b1; w_data_l <= m_axi_wdata; end
      if (aw_have && w_have && !sl_bvalid) begin
        sl_bvalid <= 1'b1;
        if (aw_addr_l < 32'd128) begin
          sl_mem[aw_addr_l[6:0]] <= w_data_l;
          sl_bresp <= RESP_OKAY;
        end else sl_bresp <= RESP_DECERR;
      end
      if (sl_bvalid && m_axi_bready) begin sl_bvalid <= 1'b0; aw_have <= 1'b0; w_have <= 1'b0; end
      if (m_axi_arvalid && m_axi_arready) begin
        sl_rvalid <= 1'b1;
        if (m_axi_araddr < 32'd128) begin
          sl_rdata <= sl_mem[m_axi_araddr[6:0]];
          sl_rresp <= RESP_OKAY;
        end else begin
          sl_rdata <= '0;
          sl_rresp <= RESP_DECERR;
        end
      end
      if (sl_rvalid && m_axi_rready) sl_rvalid <= 1'b0;
    end
  end

  // Observers: cycle count, grant log, event times, grant exclusivity.
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int   grant_log [$];
  logic busy_prev = 1'b0, awv_prev = 1'b0, arv_prev = 1'b0;
  int   awv_rise_cyc = -1, ar_rise_cyc = -1, b_hs_cyc = -1;
  int   excl_viol = 0;
  int   v;

  always @(negedge aclk) begin
    v = 0;
    if (busy && !busy_prev) grant_log.push_back(int'(grant_id));
    busy_prev <= busy;
    if (m_axi_awvalid && !awv_prev) awv_rise_cyc <= cyc;
    awv_prev <= m_axi_awvalid;
    if (m_axi_arvalid && !arv_prev) ar_rise_cyc <= cyc;
    arv_prev <= m_axi_arvalid;
    if (m_axi_bvalid && m_axi_bready) b_hs_cyc <= cyc;
    for (int i = 0; i < NM; i++)
      if ((s_axi_awready[i] | s_axi_wready[i] | s_axi_bvalid[i] | s_axi_arready[i] | s_axi_rvalid[i])
          && (!busy || int'(grant_id) != i)) v++;
    if (!busy && (m_axi_awvalid | m_axi_wvalid | m_axi_bready | m_axi_arvalid | m_axi_rready)) v++;
    excl_viol <= excl_viol + v;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int m);
    vectors++;
    miscompares++;
    $display("FAIL %s timeout on master %0d: got no handshake expected one within %0d cycles", name, m, TMO);
  endtask

  // Full write on master m; called and returns just after a rising edge.
  task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input int bdelay, output logic [1:0] resp, output int start_cyc);
    bit aw_ok, w_ok, aw_hs, w_hs, hs;
    int hold;
    start_cyc = cyc;
    awaddr_r[m] = addr; wdata_r[m] = data;
    awvalid_r[m] = 1'b1; wvalid_r[m] = 1'b1;
    aw_ok = 0; w_ok = 0;
    for (int t = 0; t < TMO && !(aw_ok && w_ok); t++) begin
      @(negedge aclk);
      aw_hs = awvalid_r[m] && s_axi_awready[m];
      w_hs  = wvalid_r[m] && s_axi_wready[m];
      @(posedge aclk); #1;
      if (aw_hs) begin awvalid_r[m] = 1'b0; aw_ok = 1; end
      if (w_hs) begin wvalid_r[m] = 1'b0; w_ok = 1; end
    end
    awvalid_r[m] = 1'b0; wvalid_r[m] = 1'b0;
    if (!(aw_ok && w_ok)) timeout("aw_w", m);
    resp = 2'bxx; hs = 0; hold = 0;
    bready_r[m] = (bdelay == 0);
    for (int t = 0; t < TMO; t++) begin
      @(negedge aclk);
      if (s_axi_bvalid[m] && bready_r[m]) begin hs = 1; resp = s_axi_bresp[m*2 +: 2]; end
      else if (s_axi_bvalid[m]) hold++;
      @(posedge aclk); #1;
      if (hs) break;
      if (bdelay > 0 && hold >= bdelay) bready_r[m] = 1'b1;
    end
    bready_r[m] = 1'b0;
    if (!hs) timeout("b", m);
  endtask

  task automatic do_read(input int m, input logic [31:0] addr, input int rdelay,
                         output logic [31:0] rdata, output logic [1:0] rresp);
    bit hs;
    int hold;
    araddr_r[m] = addr; arvalid_r[m] = 1'b1; hs = 0;
    for (int t = 0; t < TMO; t++) begin
      @(negedge aclk);
      hs = s_axi_arready[m];
      @(posedge aclk); #1;
      if (hs) break;
    end
    arvalid_r[m] = 1'b0;
    if (!hs) timeout("ar", m);
    rdata = 'x; rresp = 2'bxx; hs = 0; hold = 0;
    rready_r[m] = (rdelay == 0);
    for (int t = 0; t < TMO; t++) begin
      @(negedge aclk);
      if (s_axi_rvalid[m] && rready_r[m]) begin
        hs = 1; rdata = s_axi_rdata[m*32 +: 32]; rresp = s_axi_rresp[m*2 +: 2];
      end else if (s_axi_rvalid[m]) hold++;
      @(posedge aclk); #1;
      if (hs) break;
      if (rdelay > 0 && hold >= rdelay) rready_r[m] = 1'b1;
    end
    rready_r[m] = 1'b0;
    if (!hs) timeout("r", m);
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    for (int i = 0; i < NM; i++) begin
      awvalid_r[i] = 0; wvalid_r[i] = 0; bready_r[i] = 0; arvalid_r[i] = 0; rready_r[i] = 0;
    end
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    int          m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] ref_mem   [128];
  bit          ref_known [128];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no end of test expected one within 600000 time units");
    $fatal(1);
  end

  initial begin : main
    logic [1:0]  resp, rresp;
    logic [31:0] rdata;
    int          st, base, st1;
    bit          hs;

    for (int i = 0; i < NM; i++) begin
      awaddr_r[i] = '0; wdata_r[i] = '0; araddr_r[i] = '0;
    end
    for (int i = 0; i < 128; i++) ref_known[i] = 0;
    slv_rand = 1'b0;

    tbl[0] = '{0, 0, 32'd5,   32'h0,         RESP_OKAY,   32'hA5A5_0001};
    tbl[1] = '{1, 0, 32'd200, 32'h1111_2222, RESP_DECERR, 32'h0};
    tbl[2] = '{0, 1, 32'd5,   32'h0,         RESP_OKAY,   32'hA5A5_0001};
    tbl[3] = '{0, 1, 32'd130, 32'h0,         RESP_DECERR, 32'h0};
    tbl[4] = '{1, 1, 32'd127, 32'hDEAD_BEEF, RESP_OKAY,   32'h0};
    tbl[5] = '{0, 0, 32'd127, 32'h0,         RESP_OKAY,   32'hDEAD_BEEF};
    tbl[6] = '{1, 0, 32'd0,   32'h1234_5678, RESP_OKAY,   32'h0};
    tbl[7] = '{0, 1, 32'd0,   32'h0,         RESP_OKAY,   32'h1234_5678};

    apply_reset();
    @(negedge aclk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant", 32'(grant_id), 32'd0);
    chk("reset_m_vr", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 32'd0);
    chk("reset_s_vr", 32'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}), 32'd0);
    @(posedge aclk); #1;

    // M0 write with request-to-valid latency check.
    do_write(0, 32'd5, 32'hA5A5_0001, 0, resp, st);
    chk("wr_latency", 32'(awv_rise_cyc - st), 32'd1);
    chk("wr_bresp", 32'(resp), 32'(RESP_OKAY));
    chk("wr_grant", 32'(grant_log[$]), 32'd0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].m, tbl[i].addr, tbl[i].data, 0, resp, st);
        chk($sformatf("tbl%0d_bresp", i), 32'(resp), 32'(tbl[i].resp));
      end else begin
        do_read(tbl[i].m, tbl[i].addr, 0, rdata, rresp);
        chk($sformatf("tbl%0d_rresp", i), 32'(rresp), 32'(tbl[i].resp));
        chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rdata);
      end
      chk($sformatf("tbl%0d_grant", i), 32'(grant_log[$]), 32'(tbl[i].m));
    end

    // Simultaneous writes after reset: M0 then M1, pointer back at 0 each time.
    apply_reset();
    for (int rep = 0; rep < 4; rep++) begin
      base = grant_log.size();
      fork
        begin logic [1:0] r0; int s0; do_write(0, 32'(10 + rep), 32'(rep), 0, r0, s0); end
        begin logic [1:0] r1; int s1; do_write(1, 32'(20 + rep), 32'(rep), 0, r1, s1); end
      join
      chk($sformatf("alt%0d_first", rep), 32'(grant_log[base]), 32'd0);
      chk($sformatf("alt%0d_second", rep), 32'(grant_log[base+1]), 32'd1);
    end

    // M1 write and read together: write completes before the read address is issued.
    fork
      begin logic [1:0] r0; int s0; do_write(1, 32'd30, 32'hC0DE_0030, 0, r0, s0); end
      begin do_read(1, 32'd30, 0, rdata, rresp); end
    join
    chk("wr_then_rd_order", 32'(ar_rise_cyc > b_hs_cyc), 32'd1);
    chk("wr_then_rd_data", rdata, 32'hC0DE_0030);

    // M0 holds bready low for 10 cycles while M1 waits.
    base = grant_log.size();
    fork
      begin logic [1:0] r0; int s0; do_write(0, 32'd40, 32'h40, 10, r0, s0); end
      begin logic [1:0] r1; int s1; @(posedge aclk); #1; do_write(1, 32'd41, 32'h41, 0, r1, s1); end
      begin
        hs = 0;
        for (int t = 0; t < TMO; t++) begin
          @(negedge aclk);
          if (s_axi_bvalid[0]) begin hs = 1; break; end
        end
        if (!hs) timeout("bhold_bvalid", 0);
        else for (int k = 0; k < 10; k++) begin
          if (k > 0) @(negedge aclk);
          chk($sformatf("bhold%0d_busy", k), 32'(busy), 32'd1);
          chk($sformatf("bhold%0d_awready1", k), 32'(s_axi_awready[1]), 32'd0);
        end
      end
    join
    chk("bhold_first", 32'(grant_log[base]), 32'd0);
    chk("bhold_next", 32'(grant_log[base+1]), 32'd1);

    // Reset while M1 sits in the read-data phase.
    araddr_r[1] = 32'd5; arvalid_r[1] = 1'b1; rready_r[1] = 1'b0; hs = 0;
    for (int t = 0; t < TMO; t++) begin
      @(negedge aclk);
      hs = s_axi_arready[1];
      @(posedge aclk); #1;
      if (hs) break;
    end
    arvalid_r[1] = 1'b0;
    if (!hs) timeout("rst_ar", 1);
    @(negedge aclk);
    chk("rdrst_pre_busy", 32'(busy), 32'd1);
    chk("rdrst_pre_grant", 32'(grant_id), 32'd1);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("rdrst_busy", 32'(busy), 32'd0);
    chk("rdrst_grant", 32'(grant_id), 32'd0);
    chk("rdrst_m_vr", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 32'd0);
    chk("rdrst_s_vr", 32'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}), 32'd0);
    chk("rdrst_s_data", 32'({|s_axi_rdata, |s_axi_rresp, |s_axi_bresp}), 32'd0);
    @(posedge aclk); #1;

    // Randomized traffic from both masters against the reference memory.
    slv_rand = 1'b1;
    fork
      for (int mm = 0; mm < NM; mm++) begin
        automatic int m = mm;
        fork
          for (int n = 0; n < 40; n++) begin
            logic [31:0] a, d, rd;
            logic [1:0]  rs;
            int          s;
            repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            a = ($urandom_range(0, 7) == 0) ? 32'(128 + $urandom_range(0, 100)) : 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
              d = $urandom;
              do_write(m, a, d, $urandom_range(0, 2), rs, s);
              chk($sformatf("rnd_m%0d_bresp", m), 32'(rs), (a < 128) ? 32'(RESP_OKAY) : 32'(RESP_DECERR));
              if (a < 128) begin ref_mem[a[6:0]] = d; ref_known[a[6:0]] = 1; end
            end else begin
              do_read(m, a, $urandom_range(0, 2), rd, rs);
              chk($sformatf("rnd_m%0d_rresp", m), 32'(rs), (a < 128) ? 32'(RESP_OKAY) : 32'(RESP_DECERR));
              if (a >= 128) chk($sformatf("rnd_m%0d_rdata_err", m), rd, 32'h0);
              else if (ref_known[a[6:0]]) chk($sformatf("rnd_m%0d_rdata", m), rd, ref_mem[a[6:0]]);
            end
          end
        join_none
      end
      wait fork;
    join

    @(negedge aclk);
    chk("grant_exclusive", 32'(excl_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
